// File: rtl/mem_io_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_bridge_if
// Description : CPU strobe / SRAM pin / board I/O bundle for mem_io_bridge.
//               slave = bridge view, master = CPU + board + SRAM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_io_bridge_if #(
  parameter int ADDR_W = 20
);
  // CPU side (active-low strobes)
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [15:0]       MAR;
  logic [15:0]       MDR;
  logic [15:0]       Data_to_CPU;
  logic              Rd_Valid;
  logic              Busy;
  // Board I/O
  logic [15:0]       Switches;
  logic [15:0]       HEX_Data;
  // SRAM pins
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic [15:0]       SRAM_DQ_I;
  logic [15:0]       SRAM_DQ_O;
  logic              SRAM_DQ_OE;

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, MAR, MDR, Switches, SRAM_DQ_I,
    output Data_to_CPU, Rd_Valid, Busy, HEX_Data, SRAM_ADDR, SRAM_CE_N,
           SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_O, SRAM_DQ_OE
  );

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, MAR, MDR, Switches, SRAM_DQ_I,
    input  Data_to_CPU, Rd_Valid, Busy, HEX_Data, SRAM_ADDR, SRAM_CE_N,
           SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_O, SRAM_DQ_OE
  );
endinterface
`default_nettype wire

// File: rtl/mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_bridge
// Description : Turns SLC-3 level memory strobes into sequenced async-SRAM
//               read/write cycles and decodes the switch/hex I/O word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_bridge #(
  parameter int          ADDR_W  = 20,
  parameter int          RD_WAIT = 1,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  mem_io_bridge_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_DONE  = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5
  } state_t;

  // With no wait cycles the read goes straight to the capture state.
  localparam state_t     c_rd_first = (RD_WAIT == 0) ? ST_RD_DONE : ST_RD_WAIT;
  localparam logic [2:0] c_cnt_init = 3'(RD_WAIT - 1);

  state_t              r_state;
  logic                r_oe_q;
  logic                r_we_q;
  logic [2:0]          r_cnt;
  logic                r_io_hit;
  logic [15:0]         r_wdata;
  logic [15:0]         r_data;
  logic                r_rd_valid;
  logic [15:0]         r_hex;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ce_n;
  logic                r_ub_n;
  logic                r_lb_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic [15:0]         r_dq_o;
  logic                r_dq_oe;

  logic w_oe_edge;
  logic w_we_edge;
  logic w_io_now;

  // A request is the falling edge of a strobe while the chip is selected.
  assign w_oe_edge = r_oe_q & ~bus.Mem_OE & ~bus.Mem_CE;
  assign w_we_edge = r_we_q & ~bus.Mem_WE & ~bus.Mem_CE;
  assign w_io_now  = (bus.MAR == IO_ADDR);

  // Strobe history for edge detection; tracks the pins even while busy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_oe_q <= 1'b1;
      r_we_q <= 1'b1;
    end else begin
      r_oe_q <= bus.Mem_OE;
      r_we_q <= bus.Mem_WE;
    end
  end

  // Sequencer: every SRAM control is registered together with the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_io_hit   <= 1'b0;
      r_wdata    <= 16'h0000;
      r_data     <= 16'h0000;
      r_rd_valid <= 1'b0;
      r_hex      <= 16'h0000;
      r_addr     <= '0;
      r_ce_n     <= 1'b1;
      r_ub_n     <= 1'b1;
      r_lb_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_dq_o     <= 16'h0000;
      r_dq_oe    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_we_edge || w_oe_edge) begin
            r_addr   <= ADDR_W'(bus.MAR);
            r_wdata  <= bus.MDR;
            r_io_hit <= w_io_now;
            r_cnt    <= c_cnt_init;
            r_ce_n   <= 1'b0;
            r_ub_n   <= bus.Mem_UB;
            r_lb_n   <= bus.Mem_LB;
          end
          // A simultaneous read edge is dropped in favour of the write.
          if (w_we_edge) begin
            r_state <= ST_WR_SETUP;
            r_dq_oe <= 1'b1;
            r_dq_o  <= bus.MDR;
          end else if (w_oe_edge) begin
            r_state <= c_rd_first;
            r_oe_n  <= w_io_now;
          end
        end
        ST_RD_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) begin
            r_state <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: begin
          r_data     <= r_io_hit ? bus.Switches : bus.SRAM_DQ_I;
          r_rd_valid <= 1'b1;
          r_state    <= ST_IDLE;
          r_ce_n     <= 1'b1;
          r_oe_n     <= 1'b1;
          r_ub_n     <= 1'b1;
          r_lb_n     <= 1'b1;
        end
        ST_WR_SETUP: begin
          // I/O writes never pulse the SRAM write enable.
          r_we_n  <= r_io_hit;
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          r_we_n <= 1'b1;
          if (r_io_hit) begin
            r_hex <= r_wdata;
          end
          r_state <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          // Data stays driven for the whole cycle after WE_N rises.
          r_state <= ST_IDLE;
          r_ce_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy        = (r_state != ST_IDLE);
  assign bus.Data_to_CPU = r_data;
  assign bus.Rd_Valid    = r_rd_valid;
  assign bus.HEX_Data    = r_hex;
  assign bus.SRAM_ADDR   = r_addr;
  assign bus.SRAM_CE_N   = r_ce_n;
  assign bus.SRAM_UB_N   = r_ub_n;
  assign bus.SRAM_LB_N   = r_lb_n;
  assign bus.SRAM_OE_N   = r_oe_n;
  assign bus.SRAM_WE_N   = r_we_n;
  assign bus.SRAM_DQ_O   = r_dq_o;
  assign bus.SRAM_DQ_OE  = r_dq_oe;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_bridge
// Description : Randomized self-checking bench for mem_io_bridge with an
//               async SRAM model and a transaction-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_bridge;

  localparam int RDW = 1;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mem_io_bridge_if #(.ADDR_W(20)) bus ();
  mem_io_bridge_if #(.ADDR_W(20)) bus2 ();

  mem_io_bridge #(.ADDR_W(20), .RD_WAIT(RDW), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus.slave));

  mem_io_bridge #(.ADDR_W(20), .RD_WAIT(3), .IO_ADDR(16'hFFFF)) dut3 (
    .Clk(Clk), .Reset(Reset), .bus(bus2.slave));

  always #5 Clk = ~Clk;

  // Power-up contents of the SRAM (and of the reference memory).
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1234;
    return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
  endfunction

  // Pin-level async SRAM model: byte-lane write while CE_N and WE_N are low.
  logic [15:0] sram [0:65535];
  bit          wr_flag [0:65535];
  int          we_cnt = 0;
  logic [15:0] w_idx;
  assign w_idx = bus.SRAM_ADDR[15:0];
  assign bus.SRAM_DQ_I = wr_flag[w_idx] ? sram[w_idx] : init_val(w_idx);

  always @(posedge Clk) begin
    if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) begin
      sram[w_idx] <= {bus.SRAM_UB_N ? bus.SRAM_DQ_I[15:8] : bus.SRAM_DQ_O[15:8],
                      bus.SRAM_LB_N ? bus.SRAM_DQ_I[7:0]  : bus.SRAM_DQ_O[7:0]};
      wr_flag[w_idx] <= 1'b1;
      we_cnt <= we_cnt + 1;
    end
  end

  assign bus2.SRAM_DQ_I = (bus2.SRAM_ADDR == 20'h00040) ? 16'h0F0F : 16'hDEAD;

  // Reference model: word memory plus hex register.
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ref_hex;

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    vectors++;
    if ({bus.SRAM_CE_N, bus.SRAM_UB_N, bus.SRAM_LB_N, bus.SRAM_OE_N, bus.SRAM_WE_N,
         bus.SRAM_DQ_OE, bus.Busy, bus.Rd_Valid} !== 8'b11111000) begin
      miscompares++;
      $display("FAIL reset_ctl got %b want 11111000", {bus.SRAM_CE_N, bus.SRAM_UB_N,
        bus.SRAM_LB_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.Busy, bus.Rd_Valid});
    end
    vectors++;
    if ({bus.SRAM_ADDR, bus.SRAM_DQ_O, bus.Data_to_CPU, bus.HEX_Data} !== 68'h0) begin
      miscompares++;
      $display("FAIL reset_data got addr=%h dq=%h d=%h hex=%h want all 0",
        bus.SRAM_ADDR, bus.SRAM_DQ_O, bus.Data_to_CPU, bus.HEX_Data);
    end
    vectors++;
    if ({bus2.SRAM_CE_N, bus2.SRAM_OE_N, bus2.Busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_dut3 got %b want 110", {bus2.SRAM_CE_N, bus2.SRAM_OE_N, bus2.Busy});
    end
    Reset = 1'b0;
    ref_hex = 16'h0000;
  endtask

  // One CPU read; repulse re-asserts Mem_OE while the bridge is busy.
  task automatic do_read(input logic [15:0] addr, input int hold,
                         input logic ub, input logic lb, input bit repulse);
    logic [15:0] exp_d;
    logic        io;
    logic        busy;
    logic [7:0]  got, want;
    io    = (addr == 16'hFFFF);
    exp_d = io ? bus.Switches : ref_mem[addr];
    bus.MAR = addr; bus.Mem_UB = ub; bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0; bus.Mem_OE = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      busy = (i <= RDW + 1);
      got  = {bus.Busy, bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_DQ_OE,
              bus.Rd_Valid, bus.SRAM_UB_N, bus.SRAM_LB_N};
      want = {busy, !busy, !(busy && !io), 1'b1, 1'b0, (i == RDW + 2),
              busy ? ub : 1'b1, busy ? lb : 1'b1};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL read_ctl addr=%h cyc=%0d got %b want %b", addr, i, got, want);
      end
      if (busy) begin
        vectors++;
        if (bus.SRAM_ADDR !== {4'h0, addr}) begin
          miscompares++;
          $display("FAIL read_addr cyc=%0d got %h want %h", i, bus.SRAM_ADDR, {4'h0, addr});
        end
      end
      if (i >= RDW + 2) begin
        vectors++;
        if (bus.Data_to_CPU !== exp_d) begin
          miscompares++;
          $display("FAIL read_data addr=%h cyc=%0d got %h want %h", addr, i, bus.Data_to_CPU, exp_d);
        end
      end
      if (repulse) begin
        if (i == 1) bus.Mem_OE = 1'b1;
        if (i == 2) bus.Mem_OE = 1'b0;
      end else if (i == hold) begin
        bus.Mem_OE = 1'b1;
      end
    end
    bus.Mem_OE = 1'b1; bus.Mem_CE = 1'b1;
  endtask

  // One CPU write; with_oe drops Mem_OE in the same cycle as Mem_WE.
  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input int hold,
                          input logic ub, input logic lb, input bit with_oe);
    logic        io;
    logic        busy;
    logic [15:0] hex_exp;
    logic [7:0]  got, want;
    int          we0;
    io  = (addr == 16'hFFFF);
    we0 = we_cnt;
    bus.MAR = addr; bus.MDR = data; bus.Mem_UB = ub; bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    if (with_oe) bus.Mem_OE = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      busy = (i <= 3);
      got  = {bus.Busy, bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_DQ_OE,
              bus.Rd_Valid, bus.SRAM_UB_N, bus.SRAM_LB_N};
      want = {busy, !busy, 1'b1, !(i == 2 && !io), busy, 1'b0,
              busy ? ub : 1'b1, busy ? lb : 1'b1};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL write_ctl addr=%h cyc=%0d got %b want %b", addr, i, got, want);
      end
      if (busy) begin
        vectors++;
        if ({bus.SRAM_ADDR, bus.SRAM_DQ_O} !== {4'h0, addr, data}) begin
          miscompares++;
          $display("FAIL write_bus cyc=%0d got %h/%h want %h/%h", i, bus.SRAM_ADDR,
            bus.SRAM_DQ_O, {4'h0, addr}, data);
        end
      end
      hex_exp = (io && i >= 3) ? data : ref_hex;
      vectors++;
      if (bus.HEX_Data !== hex_exp) begin
        miscompares++;
        $display("FAIL write_hex cyc=%0d got %h want %h", i, bus.HEX_Data, hex_exp);
      end
      if (i == hold) begin
        bus.Mem_WE = 1'b1; bus.Mem_OE = 1'b1;
      end
    end
    bus.Mem_WE = 1'b1; bus.Mem_OE = 1'b1; bus.Mem_CE = 1'b1;
    if (io) begin
      ref_hex = data;
    end else begin
      if (!ub) ref_mem[addr] = (ref_mem[addr] & 16'h00FF) | (data & 16'hFF00);
      if (!lb) ref_mem[addr] = (ref_mem[addr] & 16'hFF00) | (data & 16'h00FF);
      vectors++;
      if ((wr_flag[addr] ? sram[addr] : init_val(addr)) !== ref_mem[addr]) begin
        miscompares++;
        $display("FAIL write_mem addr=%h got %h want %h", addr, sram[addr], ref_mem[addr]);
      end
    end
    vectors++;
    if (we_cnt - we0 !== (io ? 0 : 1)) begin
      miscompares++;
      $display("FAIL write_count addr=%h got %0d want %0d", addr, we_cnt - we0, io ? 0 : 1);
    end
  endtask

  task automatic test_basic();
    do_read(16'h0010, 2, 1'b0, 1'b0, 1'b0);
    do_write(16'h0020, 16'hBEEF, 2, 1'b0, 1'b0, 1'b0);
    do_write(16'h0021, 16'hCAFE, 5, 1'b0, 1'b0, 1'b0);
    do_read(16'h0020, 1, 1'b0, 1'b0, 1'b0);
    do_read(16'h0010, 4, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_io();
    do_write(16'hFFFF, 16'h00A5, 2, 1'b0, 1'b0, 1'b0);
    bus.Switches = 16'h3C3C;
    do_read(16'hFFFF, 2, 1'b0, 1'b0, 1'b0);
    do_write(16'hFFFE, 16'h9876, 2, 1'b0, 1'b0, 1'b0);
    do_read(16'hFFFE, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    do_write(16'h0050, 16'h5555, 2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    bus.MAR = 16'h0030; bus.MDR = 16'h7777; bus.Mem_UB = 1'b0; bus.Mem_LB = 1'b0;
    bus.Mem_CE = 1'b0; bus.Mem_WE = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    vectors++;
    if (bus.SRAM_WE_N !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pulse got WE_N=%b want 0", bus.SRAM_WE_N);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    vectors++;
    if ({bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.Busy, bus.SRAM_CE_N, bus.HEX_Data} !== {4'b1001, 16'h0}) begin
      miscompares++;
      $display("FAIL abort_reset got we=%b oe=%b busy=%b ce=%b hex=%h want 1 0 0 1 0000",
        bus.SRAM_WE_N, bus.SRAM_DQ_OE, bus.Busy, bus.SRAM_CE_N, bus.HEX_Data);
    end
    @(negedge Clk);
    Reset = 1'b0;
    bus.Mem_WE = 1'b1; bus.Mem_CE = 1'b1;
    ref_hex = 16'h0000;
    @(negedge Clk);
    do_read(16'h0010, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_rd_wait3();
    logic busy;
    logic [2:0] got, want;
    bus2.MAR = 16'h0040; bus2.Mem_CE = 1'b0; bus2.Mem_OE = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      busy = (i <= 4);
      got  = {bus2.Busy, bus2.SRAM_OE_N, bus2.Rd_Valid};
      want = {busy, !busy, (i == 5)};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rdw3_ctl cyc=%0d got %b want %b", i, got, want);
      end
      if (i >= 5) begin
        vectors++;
        if (bus2.Data_to_CPU !== 16'h0F0F) begin
          miscompares++;
          $display("FAIL rdw3_data cyc=%0d got %h want 0f0f", i, bus2.Data_to_CPU);
        end
      end
      if (i == 2) bus2.Mem_OE = 1'b1;
      if (i == 3) bus2.Mem_OE = 1'b0;
    end
    bus2.Mem_OE = 1'b1; bus2.Mem_CE = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] addr;
    int          sel;
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 9);
      addr = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'hFFFE : 16'h0100 + 16'($urandom_range(0, 15));
      bus.Switches = 16'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_read(addr, $urandom_range(1, 4), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      else
        do_write(addr, 16'($urandom), $urandom_range(1, 5), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    ref_hex = 16'h0000;
    bus.Mem_CE = 1'b1; bus.Mem_UB = 1'b1; bus.Mem_LB = 1'b1;
    bus.Mem_OE = 1'b1; bus.Mem_WE = 1'b1;
    bus.MAR = 16'h0000; bus.MDR = 16'h0000; bus.Switches = 16'h0000;
    bus2.Mem_CE = 1'b1; bus2.Mem_UB = 1'b0; bus2.Mem_LB = 1'b0;
    bus2.Mem_OE = 1'b1; bus2.Mem_WE = 1'b1;
    bus2.MAR = 16'h0000; bus2.MDR = 16'h0000; bus2.Switches = 16'h0000;
    test_reset();
    test_basic();
    test_io();
    test_collision();
    test_reset_abort();
    test_rd_wait3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
